// File: rtl/plic_gateway.sv
// Interrupt gateway: synchronises raw device lines, applies polarity and level/edge
// triggering, and issues one PLIC request pulse per source until its claim/complete.
module plic_gateway #(
  parameter int NUM_SRC     = 31,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_SRC:1]   irq_in,
  input  logic               complete_valid,
  input  logic [7:0]         complete_id,
  input  logic               valid,
  input  logic [7:0]         addr,
  input  logic [3:0]         wmask,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               is_valid,
  output logic               ready,
  output logic [NUM_SRC:1]   interrupt_request
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] ADDR_TRIGGER  = 8'h00;
  localparam logic [7:0] ADDR_POLARITY = 8'h04;
  localparam logic [7:0] ADDR_LEVEL    = 8'h08;
  localparam logic [7:0] ADDR_INFLIGHT = 8'h0C;
  localparam logic [7:0] ADDR_EDGE_LAT = 8'h10;

  function automatic logic [31:0] byte_en(input logic [3:0] m);
    logic [31:0] r;
    r = 32'd0;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = {8{m[b]}};
    end
    return r;
  endfunction

  function automatic logic [31:0] widen(input logic [NUM_SRC:1] v);
    logic [31:0] r;
    r = 32'd0;
    r[NUM_SRC:1] = v;
    return r;
  endfunction

  logic [SYNC_STAGES-1:0][NUM_SRC:1] r_sync;
  logic [NUM_SRC:1] r_trigger;
  logic [NUM_SRC:1] r_polarity;
  logic [NUM_SRC:1] r_prev_act;
  logic [NUM_SRC:1] r_edge_lat;
  logic [NUM_SRC:1] r_req;
  logic             r_ready;
  state_t           r_state     [NUM_SRC:1];
  state_t           w_state_nxt [NUM_SRC:1];

  logic [NUM_SRC:1] w_act;
  logic [NUM_SRC:1] w_edge;
  logic [NUM_SRC:1] w_complete;
  logic [NUM_SRC:1] w_w1c;
  logic [NUM_SRC:1] w_trigger_nxt;
  logic [NUM_SRC:1] w_polarity_nxt;
  logic [NUM_SRC:1] w_edge_lat_nxt;
  logic [NUM_SRC:1] w_fire_nxt;
  logic [NUM_SRC:1] w_inflight;
  logic [31:0]      w_wm;
  logic             w_bus_wr;
  logic             w_unused;

  assign is_valid          = valid && !r_ready;
  assign ready             = r_ready;
  assign interrupt_request = r_req;
  assign w_bus_wr          = is_valid && (wmask != 4'd0);
  assign w_wm              = byte_en(wmask);
  assign w_act             = r_sync[SYNC_STAGES-1] ^ r_polarity;
  assign w_edge            = w_act & ~r_prev_act;
  assign w_unused          = ^(wdata & w_wm & ~widen({NUM_SRC{1'b1}}));

  // Byte-masked configuration writes and INFLIGHT write-1-to-clear strobes.
  always_comb begin
    w_trigger_nxt  = r_trigger;
    w_polarity_nxt = r_polarity;
    w_w1c          = '0;
    if (w_bus_wr && (addr == ADDR_TRIGGER)) begin
      w_trigger_nxt = (r_trigger & ~w_wm[NUM_SRC:1]) | (wdata[NUM_SRC:1] & w_wm[NUM_SRC:1]);
    end else begin
      w_trigger_nxt = r_trigger;
    end
    if (w_bus_wr && (addr == ADDR_POLARITY)) begin
      w_polarity_nxt = (r_polarity & ~w_wm[NUM_SRC:1]) | (wdata[NUM_SRC:1] & w_wm[NUM_SRC:1]);
    end else begin
      w_polarity_nxt = r_polarity;
    end
    if (w_bus_wr && (addr == ADDR_INFLIGHT)) begin
      w_w1c = wdata[NUM_SRC:1] & w_wm[NUM_SRC:1];
    end else begin
      w_w1c = '0;
    end
  end

  // Completion decode; id 0 and ids above NUM_SRC can never match a source.
  always_comb begin
    w_complete = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_complete[k] = complete_valid && (complete_id == 8'(k));
    end
  end

  // Per-source next state and edge latch; a complete takes priority over a W1C.
  always_comb begin
    w_edge_lat_nxt = r_edge_lat;
    w_fire_nxt     = '0;
    w_inflight     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_state_nxt[k] = r_state[k];
      w_inflight[k]  = (r_state[k] == ST_WAIT);
      case (r_state[k])
        ST_IDLE: begin
          if (r_trigger[k] ? w_edge[k] : w_act[k]) begin
            w_state_nxt[k] = ST_FIRE;
          end else begin
            w_state_nxt[k] = ST_IDLE;
          end
        end
        ST_FIRE: begin
          w_state_nxt[k] = ST_WAIT;
        end
        ST_WAIT: begin
          if (w_complete[k]) begin
            if (r_trigger[k] && (r_edge_lat[k] || w_edge[k])) begin
              w_state_nxt[k] = ST_FIRE;
            end else begin
              w_state_nxt[k] = ST_IDLE;
            end
            w_edge_lat_nxt[k] = 1'b0;
          end else if (w_w1c[k]) begin
            w_state_nxt[k]    = ST_IDLE;
            w_edge_lat_nxt[k] = 1'b0;
          end else if (r_trigger[k] && w_edge[k]) begin
            w_edge_lat_nxt[k] = 1'b1;
          end else begin
            w_edge_lat_nxt[k] = r_edge_lat[k];
          end
        end
        default: begin
          w_state_nxt[k]    = ST_IDLE;
          w_edge_lat_nxt[k] = 1'b0;
        end
      endcase
      // A latch is only meaningful while the source is edge-triggered.
      w_edge_lat_nxt[k] = w_edge_lat_nxt[k] & w_trigger_nxt[k];
      w_fire_nxt[k]     = (w_state_nxt[k] == ST_FIRE);
    end
  end

  // Per-source FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        r_state[k] <= ST_IDLE;
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        r_state[k] <= w_state_nxt[k];
      end
    end
  end

  // Synchronisers, configuration, latches, request pulses and bus acknowledge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync     <= '0;
      r_trigger  <= '0;
      r_polarity <= '0;
      r_prev_act <= '0;
      r_edge_lat <= '0;
      r_req      <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_sync[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_trigger  <= w_trigger_nxt;
      r_polarity <= w_polarity_nxt;
      r_prev_act <= w_act;
      r_edge_lat <= w_edge_lat_nxt;
      r_req      <= w_fire_nxt;
      r_ready    <= is_valid;
    end
  end

  // Read mux, combinational from addr; unmapped offsets return zero.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_TRIGGER:  rdata = widen(r_trigger);
      ADDR_POLARITY: rdata = widen(r_polarity);
      ADDR_LEVEL:    rdata = widen(w_act);
      ADDR_INFLIGHT: rdata = widen(w_inflight);
      ADDR_EDGE_LAT: rdata = widen(r_edge_lat);
      default:       rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: register table plus multi-cycle interrupt sequences.
module tb_plic_gateway;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:1] irq_in;
  logic        complete_valid;
  logic [7:0]  complete_id;
  logic        valid;
  logic [7:0]  addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        is_valid;
  logic        ready;
  logic [31:1] interrupt_request;

  int checks = 0;
  int errors = 0;
  int pcnt [1:31];

  plic_gateway #(.NUM_SRC(31), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .irq_in(irq_in),
    .complete_valid(complete_valid), .complete_id(complete_id),
    .valid(valid), .addr(addr), .wmask(wmask), .wdata(wdata),
    .rdata(rdata), .is_valid(is_valid), .ready(ready),
    .interrupt_request(interrupt_request)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 1; k <= 31; k++) pcnt[k] = 0;
  end

  always @(negedge clk) begin
    for (int k = 1; k <= 31; k++) begin
      if (interrupt_request[k] === 1'b1) pcnt[k] = pcnt[k] + 1;
    end
  end

  typedef struct {
    logic [7:0]  waddr;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [7:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    irq_in = '0;
    complete_valid = 1'b0;
    complete_id = 8'd0;
    valid = 1'b0;
    addr = 8'd0;
    wmask = 4'd0;
    wdata = 32'd0;
    wait_n(2);
    resetn = 1'b1;
    tick();
  endtask

  task automatic bus_acc(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
    valid = 1'b1;
    addr = a;
    wmask = m;
    wdata = d;
    tick();
    valid = 1'b0;
    wmask = 4'd0;
    tick();
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic complete(input logic [7:0] id);
    complete_valid = 1'b1;
    complete_id = id;
    tick();
    complete_valid = 1'b0;
    complete_id = 8'd0;
  endtask

  logic [31:0] v;
  int base, base2;

  initial begin
    tbl[0]  = '{8'h00, 4'hF, 32'hFFFFFFFF, 8'h00, 32'hFFFFFFFE};
    tbl[1]  = '{8'h00, 4'h1, 32'h00000000, 8'h00, 32'hFFFFFF00};
    tbl[2]  = '{8'h00, 4'h6, 32'h00000000, 8'h00, 32'hFF000000};
    tbl[3]  = '{8'h00, 4'hF, 32'h00000000, 8'h00, 32'h00000000};
    tbl[4]  = '{8'h04, 4'h1, 32'h000000FF, 8'h04, 32'h000000FE};
    tbl[5]  = '{8'h08, 4'hF, 32'hFFFFFFFF, 8'h08, 32'h000000FE};
    tbl[6]  = '{8'h10, 4'hF, 32'hFFFFFFFF, 8'h10, 32'h00000000};
    tbl[7]  = '{8'h14, 4'hF, 32'hFFFFFFFF, 8'h14, 32'h00000000};
    tbl[8]  = '{8'h04, 4'hF, 32'h00000000, 8'h04, 32'h00000000};
    tbl[9]  = '{8'h08, 4'h0, 32'h00000000, 8'h08, 32'h00000000};
    tbl[10] = '{8'h0C, 4'h0, 32'h00000000, 8'h0C, 32'h000000FE};
    tbl[11] = '{8'h0C, 4'h1, 32'h0000000E, 8'h0C, 32'h000000F0};
    tbl[12] = '{8'h0C, 4'hF, 32'hFFFFFFFF, 8'h0C, 32'h00000000};
    tbl[13] = '{8'h00, 4'h8, 32'h80000000, 8'h00, 32'h80000000};
    tbl[14] = '{8'h00, 4'hF, 32'h00000001, 8'h00, 32'h00000000};

    do_reset();
    chk("reset_req", interrupt_request, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);

    // Register access table
    for (int i = 0; i < 15; i++) begin
      bus_acc(tbl[i].waddr, tbl[i].wm, tbl[i].wd);
      rd(tbl[i].raddr, v);
      chk($sformatf("reg_vec%0d", i), v, tbl[i].exp);
    end

    // 1: level latency and re-fire after complete
    do_reset();
    base = pcnt[3];
    irq_in[3] = 1'b1;
    tick(); chk("t1_lat_e0", {31'd0, interrupt_request[3]}, 32'd0);
    tick(); chk("t1_lat_e1", {31'd0, interrupt_request[3]}, 32'd0);
    tick(); chk("t1_lat_e2", {31'd0, interrupt_request[3]}, 32'd1);
    tick(); chk("t1_lat_e3", {31'd0, interrupt_request[3]}, 32'd0);
    rd(8'h0C, v); chk("t1_inflight", v, 32'h00000008);
    complete(8'd3);
    chk("t1_idle_req", {31'd0, interrupt_request[3]}, 32'd0);
    tick(); chk("t1_refire", {31'd0, interrupt_request[3]}, 32'd1);
    tick(); chk("t1_refire_end", {31'd0, interrupt_request[3]}, 32'd0);
    irq_in[3] = 1'b0;
    wait_n(4);
    complete(8'd3);
    wait_n(3);
    rd(8'h0C, v); chk("t1_inflight_end", v, 32'd0);
    chk("t1_pulses", pcnt[3] - base, 32'd2);

    // 2: edge mode, latched edge while masked
    do_reset();
    bus_acc(8'h00, 4'hF, 32'h00000004);
    base = pcnt[2];
    for (int p = 0; p < 4; p++) begin
      irq_in[2] = 1'b1; wait_n(3);
      irq_in[2] = 1'b0; wait_n(3);
    end
    chk("t2_one_pulse", pcnt[2] - base, 32'd1);
    rd(8'h10, v); chk("t2_edge_lat", v, 32'h00000004);
    complete(8'd2);
    wait_n(4);
    chk("t2_second_pulse", pcnt[2] - base, 32'd2);
    rd(8'h10, v); chk("t2_lat_clear", v, 32'd0);
    rd(8'h0C, v); chk("t2_inflight", v, 32'h00000004);
    complete(8'd2);
    wait_n(3);
    rd(8'h0C, v); chk("t2_inflight_end", v, 32'd0);
    chk("t2_no_more", pcnt[2] - base, 32'd2);

    // 3: ignored completes
    do_reset();
    irq_in[6] = 1'b1; irq_in[8] = 1'b1;
    wait_n(5);
    irq_in = '0;
    wait_n(4);
    rd(8'h0C, v); chk("t3_inflight_pre", v, 32'h00000140);
    base = pcnt[5] + pcnt[6] + pcnt[8];
    complete(8'd0);
    complete(8'd40);
    complete(8'd5);
    wait_n(3);
    rd(8'h0C, v); chk("t3_inflight_post", v, 32'h00000140);
    chk("t3_no_pulse", pcnt[5] + pcnt[6] + pcnt[8] - base, 32'd0);
    complete(8'd6);
    rd(8'h0C, v); chk("t3_complete6", v, 32'h00000100);

    // 4: polarity
    do_reset();
    base = pcnt[1];
    bus_acc(8'h04, 4'hF, 32'h00000002);
    rd(8'h08, v); chk("t4_level", v, 32'h00000002);
    wait_n(3);
    chk("t4_fire", pcnt[1] - base, 32'd1);
    irq_in[1] = 1'b1;
    wait_n(4);
    rd(8'h08, v); chk("t4_level_off", v, 32'd0);
    complete(8'd1);
    wait_n(4);
    chk("t4_no_refire", pcnt[1] - base, 32'd1);
    rd(8'h0C, v); chk("t4_inflight", v, 32'd0);

    // 5: recovery via W1C, simultaneous W1C+complete, bus handshake
    do_reset();
    base = pcnt[7];
    irq_in[7] = 1'b1;
    wait_n(5);
    rd(8'h0C, v); chk("t5_inflight", v, 32'h00000080);
    chk("t5_first", pcnt[7] - base, 32'd1);
    bus_acc(8'h0C, 4'hF, 32'h00000080);
    chk("t5_refire_req", {31'd0, interrupt_request[7]}, 32'd1);
    rd(8'h0C, v); chk("t5_inflight_clr", v, 32'd0);
    wait_n(3);
    chk("t5_refire_cnt", pcnt[7] - base, 32'd2);
    valid = 1'b1; addr = 8'h0C; wmask = 4'hF; wdata = 32'h00000080;
    complete_valid = 1'b1; complete_id = 8'd7;
    tick();
    valid = 1'b0; wmask = 4'd0; complete_valid = 1'b0; complete_id = 8'd0;
    wait_n(4);
    chk("t5_dual_once", pcnt[7] - base, 32'd3);
    rd(8'h0C, v); chk("t5_dual_wait", v, 32'h00000080);
    valid = 1'b1; addr = 8'h00; wmask = 4'h1; wdata = 32'hFFFFFFFF;
    #1;
    chk("t5_isvalid", {31'd0, is_valid}, 32'd1);
    chk("t5_ready_lo", {31'd0, ready}, 32'd0);
    tick();
    chk("t5_ready_hi", {31'd0, ready}, 32'd1);
    chk("t5_isvalid_lo", {31'd0, is_valid}, 32'd0);
    valid = 1'b0; wmask = 4'd0;
    tick();
    chk("t5_ready_drop", {31'd0, ready}, 32'd0);
    rd(8'h00, v); chk("t5_byte0", v, 32'h000000FE);

    // 6: async reset mid WAIT/FIRE
    do_reset();
    bus_acc(8'h00, 4'hF, 32'h00000210);
    for (int p = 0; p < 2; p++) begin
      irq_in[4] = 1'b1; irq_in[9] = 1'b1; wait_n(3);
      irq_in[4] = 1'b0; irq_in[9] = 1'b0; wait_n(3);
    end
    rd(8'h10, v); chk("t6_latches", v, 32'h00000210);
    rd(8'h0C, v); chk("t6_inflight", v, 32'h00000210);
    complete(8'd4);
    chk("t6_fire4", {31'd0, interrupt_request[4]}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_req_async", interrupt_request, 32'd0);
    chk("t6_ready_async", {31'd0, ready}, 32'd0);
    rd(8'h10, v); chk("t6_lat_async", v, 32'd0);
    wait_n(2);
    resetn = 1'b1;
    tick();
    for (int a = 0; a <= 16; a += 4) begin
      rd(8'(a), v);
      chk($sformatf("t6_reg%0h", a), v, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
